// File: rtl/mem_access_stage.sv
// MEM stage: byte-addressed data memory with sub-word loads/stores, branch resolution,
// misalignment detection and a handshaked memory-dump sequencer for the debug unit.
module mem_access_stage #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_PC   = 6,
  parameter int unsigned NB_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [4:0]         i_control_bits,
  input  logic               i_zero,
  input  logic [NB_PC-1:0]   i_sum,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic [NB_DATA-1:0] i_read_data2,
  input  logic [2:0]         i_funct3,
  input  logic [1:0]         i_pipeline_mode,
  input  logic               i_execute_instruct,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic [NB_DATA-1:0] o_read_data,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic               o_mem_to_reg,
  output logic               o_reg_write,
  output logic               o_pc_src,
  output logic [NB_PC-1:0]   o_branch_target,
  output logic               o_misaligned,
  output logic               o_misaligned_sticky,
  output logic               o_dump_valid,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_word,
  output logic               o_dump_done
);

  localparam int unsigned NWords = 2 ** NB_ADDR;

  typedef enum logic [1:0] {StIdle, StDump, StDone} dump_state_e;

  logic [NB_DATA-1:0] r_mem [NWords];
  logic               r_sticky;
  dump_state_e        r_state, w_state_next;
  logic [NB_ADDR-1:0] r_dump_addr, w_dump_addr_next;

  logic               w_mem_read, w_mem_write, w_access, w_step_en;
  logic [NB_ADDR-1:0] w_word_idx;
  logic [1:0]         w_off;
  logic [NB_DATA-1:0] w_rd_word, w_wr_word, w_wr_data, w_ext;
  logic [3:0]         w_lane_en;
  logic               w_misalign_raw, w_store;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic               w_unused_addr;

  assign w_mem_read  = i_control_bits[0];
  assign w_mem_write = i_control_bits[1];
  assign w_access    = w_mem_read | w_mem_write;
  assign w_step_en   = (i_pipeline_mode == 2'b01) |
                       ((i_pipeline_mode == 2'b11) & i_execute_instruct);

  // Upper address bits are ignored so accesses wrap modulo the memory size.
  assign w_word_idx    = i_alu_result[NB_ADDR+1:2];
  assign w_off         = i_alu_result[1:0];
  assign w_unused_addr = ^i_alu_result[NB_DATA-1:NB_ADDR+2];
  assign w_rd_word     = r_mem[w_word_idx];

  assign o_alu_result    = i_alu_result;
  assign o_mem_to_reg    = i_control_bits[3];
  assign o_reg_write     = i_control_bits[4];
  assign o_pc_src        = i_control_bits[2] & i_zero;
  assign o_branch_target = i_sum;

  // Alignment check by access size; undefined funct3 behaves as a word access.
  always_comb begin
    unique case (i_funct3)
      3'b000, 3'b100: w_misalign_raw = 1'b0;
      3'b001, 3'b101: w_misalign_raw = w_off[0];
      default:        w_misalign_raw = (w_off != 2'b00);
    endcase
  end

  assign o_misaligned        = w_access & w_misalign_raw;
  assign w_store             = w_mem_write & w_step_en & ~w_misalign_raw;
  assign o_misaligned_sticky = r_sticky;

  // Store lane enables and replicated store data, merged over the old word.
  always_comb begin
    unique case (i_funct3)
      3'b000, 3'b100: begin
        w_lane_en = 4'b0001 << w_off;
        w_wr_data = {4{i_read_data2[7:0]}};
      end
      3'b001, 3'b101: begin
        w_lane_en = w_off[1] ? 4'b1100 : 4'b0011;
        w_wr_data = {2{i_read_data2[15:0]}};
      end
      default: begin
        w_lane_en = 4'b1111;
        w_wr_data = i_read_data2;
      end
    endcase
    w_wr_word = w_rd_word;
    for (int b = 0; b < 4; b++) begin
      if (w_lane_en[b]) w_wr_word[8*b +: 8] = w_wr_data[8*b +: 8];
    end
  end

  // Load byte/half selection and sign/zero extension.
  always_comb begin
    unique case (w_off)
      2'd0:    w_byte = w_rd_word[7:0];
      2'd1:    w_byte = w_rd_word[15:8];
      2'd2:    w_byte = w_rd_word[23:16];
      default: w_byte = w_rd_word[31:24];
    endcase
    w_half = w_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    unique case (i_funct3)
      3'b000:  w_ext = {{(NB_DATA-8){w_byte[7]}}, w_byte};
      3'b100:  w_ext = {{(NB_DATA-8){1'b0}}, w_byte};
      3'b001:  w_ext = {{(NB_DATA-16){w_half[15]}}, w_half};
      3'b101:  w_ext = {{(NB_DATA-16){1'b0}}, w_half};
      default: w_ext = w_rd_word;
    endcase
    o_read_data = (w_mem_read & ~w_misalign_raw) ? w_ext : '0;
  end

  // Data memory: cleared on reset, written on enabled aligned stores.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NWords; i++) r_mem[i] <= '0;
    end else if (w_store) begin
      r_mem[w_word_idx] <= w_wr_word;
    end
  end

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_sticky <= 1'b0;
    else if (w_step_en & w_access & w_misalign_raw) r_sticky <= 1'b1;
  end

  // Dump sequencer state and address registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_dump_addr <= '0;
    end else begin
      r_state     <= w_state_next;
      r_dump_addr <= w_dump_addr_next;
    end
  end

  // Dump sequencer next state and outputs.
  always_comb begin
    w_state_next     = r_state;
    w_dump_addr_next = r_dump_addr;
    o_dump_valid     = 1'b0;
    o_dump_done      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_dump_start) begin
          w_state_next     = StDump;
          w_dump_addr_next = '0;
        end
      end
      StDump: begin
        o_dump_valid = 1'b1;
        if (i_dump_ready) begin
          if (r_dump_addr == {NB_ADDR{1'b1}}) w_state_next = StDone;
          else w_dump_addr_next = r_dump_addr + 1'b1;
        end
      end
      StDone: begin
        o_dump_done  = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_dump_addr = r_dump_addr;
  assign o_dump_word = r_mem[r_dump_addr];

endmodule
